otter_fetch_stage: RTL and testbench



---
 rtl/otter_pkg.sv | 14 +
 rtl/otter_pc_reg.sv | 42 ++++
 rtl/otter_fetch_stage.sv | 75 +++++++
 tb/tb_otter_fetch_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER pipeline definitions: reset vector, canonical NOP and the IF/ID bundle.
package otter_pkg;

  localparam logic [31:0] OTTER_NOP      = 32'h0000_0013;
  localparam logic [31:0] OTTER_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/otter_pc_reg.sv
// Program counter with reset/redirect/hold/increment selection and sticky misalign flag.
module otter_pc_reg
  import otter_pkg::*;
#(
  parameter logic [31:0] ResetPc = OTTER_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (rst_i) begin
      pc_d       = ResetPc;
      misalign_d = 1'b0;
    end else if (flush_i) begin
      // Low bits are dropped; a non-zero offset only raises the flag.
      pc_d = {target_i[31:2], 2'b00};
      if (target_i[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (!stall_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    pc_q       <= pc_d;
    misalign_q <= misalign_d;
  end

  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction fetch: drives the BRAM instruction port and presents the IF/ID register view.
module otter_fetch_stage
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = OTTER_RESET_PC,
  parameter logic [31:0] NOP_INSTR = OTTER_NOP
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] TARGET,
  input  logic [31:0] MEM_DOUT1,
  output logic [13:0] MEM_ADDR1,
  output logic        MEM_RDEN1,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC4,
  output logic [31:0] IF_INSTR,
  output logic        IF_VALID,
  output logic        FETCH_MISALIGN
);

  logic [31:0] pc;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  if_id_t      if_id;

  otter_pc_reg #(
    .ResetPc(RESET_PC)
  ) u_pc_reg (
    .clk_i     (CLK),
    .rst_i     (RST),
    .flush_i   (FLUSH),
    .stall_i   (STALL),
    .target_i  (TARGET),
    .pc_o      (pc),
    .misalign_o(FETCH_MISALIGN)
  );

  always_comb begin
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    if (RST) begin
      if_pc_d    = 32'd0;
      if_valid_d = 1'b0;
    end else if (FLUSH) begin
      if_valid_d = 1'b0;
    end else if (!STALL) begin
      if_pc_d    = pc;
      if_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if_pc_q    <= if_pc_d;
    if_valid_q <= if_valid_d;
  end

  // Deasserting the read enable during a stall makes the BRAM hold its output word.
  assign MEM_ADDR1 = pc[15:2];
  assign MEM_RDEN1 = RST | FLUSH | ~STALL;

  always_comb begin
    if_id.pc    = if_pc_q;
    if_id.pc4   = if_pc_q + 32'd4;
    if_id.instr = if_valid_q ? MEM_DOUT1 : NOP_INSTR;
    if_id.valid = if_valid_q;
  end

  assign IF_PC    = if_id.pc;
  assign IF_PC4   = if_id.pc4;
  assign IF_INSTR = if_id.instr;
  assign IF_VALID = if_id.valid;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed bench for otter_fetch_stage with a behavioural synchronous instruction BRAM.
module tb_otter_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] target;
  logic [31:0] mem_dout;
  logic [13:0] mem_addr;
  logic        mem_rden;
  logic [31:0] if_pc, if_pc4, if_instr;
  logic        if_valid, misalign;

  logic [31:0] mem [16384];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rden) mem_dout <= mem[mem_addr];
  end

  otter_fetch_stage dut (
    .CLK           (clk),
    .RST           (rst),
    .STALL         (stall),
    .FLUSH         (flush),
    .TARGET        (target),
    .MEM_DOUT1     (mem_dout),
    .MEM_ADDR1     (mem_addr),
    .MEM_RDEN1     (mem_rden),
    .IF_PC         (if_pc),
    .IF_PC4        (if_pc4),
    .IF_INSTR      (if_instr),
    .IF_VALID      (if_valid),
    .FETCH_MISALIGN(misalign)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; target = 32'h0;
    step(); step();
    vectors++; if (mem_addr !== 14'd0) begin miscompares++; $display("FAIL rst_addr got %h exp %h", mem_addr, 14'd0); end
    vectors++; if (mem_rden !== 1'b1) begin miscompares++; $display("FAIL rst_rden got %b exp 1", mem_rden); end
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h exp 0", if_pc); end
    vectors++; if (if_pc4 !== 32'h4) begin miscompares++; $display("FAIL rst_pc4 got %h exp 4", if_pc4); end
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", if_valid); end
    vectors++; if (if_instr !== 32'h13) begin miscompares++; $display("FAIL rst_instr got %h exp 13", if_instr); end
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL rst_misalign got %b exp 0", misalign); end
  endtask

  task automatic test_free_run();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL run_valid[%0d] got %b exp 1", i, if_valid); end
      vectors++; if (if_pc !== 32'(4 * i)) begin miscompares++; $display("FAIL run_pc[%0d] got %h exp %h", i, if_pc, 32'(4 * i)); end
      vectors++; if (if_pc4 !== 32'(4 * i + 4)) begin miscompares++; $display("FAIL run_pc4[%0d] got %h exp %h", i, if_pc4, 32'(4 * i + 4)); end
      vectors++; if (if_instr !== 32'h1000_0000 + 32'(i)) begin miscompares++; $display("FAIL run_instr[%0d] got %h exp %h", i, if_instr, 32'h1000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    vectors++; if (mem_rden !== 1'b0) begin miscompares++; $display("FAIL stall_rden got %b exp 0", mem_rden); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (if_pc !== 32'h8) begin miscompares++; $display("FAIL stall_pc[%0d] got %h exp 8", i, if_pc); end
      vectors++; if (if_instr !== 32'h1000_0002) begin miscompares++; $display("FAIL stall_instr[%0d] got %h exp 10000002", i, if_instr); end
      vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d] got %b exp 1", i, if_valid); end
      vectors++; if (mem_addr !== 14'd3) begin miscompares++; $display("FAIL stall_addr[%0d] got %h exp 3", i, mem_addr); end
    end
    stall = 1'b0;
    step();
    vectors++; if (if_pc !== 32'hC) begin miscompares++; $display("FAIL unstall_pc got %h exp c", if_pc); end
    vectors++; if (if_instr !== 32'h1000_0003) begin miscompares++; $display("FAIL unstall_instr got %h exp 10000003", if_instr); end
  endtask

  task automatic test_flush_over_stall();
    stall = 1'b1; flush = 1'b1; target = 32'h40;
    #1;
    vectors++; if (mem_rden !== 1'b1) begin miscompares++; $display("FAIL flush_rden got %b exp 1", mem_rden); end
    step();
    flush = 1'b0; stall = 1'b0;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b exp 0", if_valid); end
    vectors++; if (if_instr !== 32'h13) begin miscompares++; $display("FAIL flush_instr got %h exp 13", if_instr); end
    vectors++; if (mem_addr !== 14'h10) begin miscompares++; $display("FAIL flush_addr got %h exp 10", mem_addr); end
    vectors++; if (if_pc !== 32'hC) begin miscompares++; $display("FAIL flush_pc_hold got %h exp c", if_pc); end
    step();
    vectors++; if (if_pc !== 32'h40) begin miscompares++; $display("FAIL redir_pc got %h exp 40", if_pc); end
    vectors++; if (if_instr !== 32'h1000_0010) begin miscompares++; $display("FAIL redir_instr got %h exp 10000010", if_instr); end
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL aligned_misalign got %b exp 0", misalign); end
  endtask

  task automatic test_misalign();
    flush = 1'b1; target = 32'h42;
    step();
    flush = 1'b0;
    vectors++; if (misalign !== 1'b1) begin miscompares++; $display("FAIL mis_flag got %b exp 1", misalign); end
    step();
    vectors++; if (if_pc !== 32'h40) begin miscompares++; $display("FAIL mis_pc got %h exp 40", if_pc); end
    vectors++; if (if_instr !== 32'h1000_0010) begin miscompares++; $display("FAIL mis_instr got %h exp 10000010", if_instr); end
    step();
    vectors++; if (if_pc !== 32'h44) begin miscompares++; $display("FAIL mis_next_pc got %h exp 44", if_pc); end
    vectors++; if (misalign !== 1'b1) begin miscompares++; $display("FAIL mis_sticky got %b exp 1", misalign); end
  endtask

  task automatic test_back_to_back();
    flush = 1'b1; target = 32'h80;
    step();
    target = 32'h100;
    step();
    flush = 1'b0;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid got %b exp 0", if_valid); end
    vectors++; if (mem_addr !== 14'h40) begin miscompares++; $display("FAIL b2b_addr got %h exp 40", mem_addr); end
    step();
    vectors++; if (if_pc !== 32'h100) begin miscompares++; $display("FAIL b2b_pc got %h exp 100", if_pc); end
    vectors++; if (if_instr !== 32'h1000_0040) begin miscompares++; $display("FAIL b2b_instr got %h exp 10000040", if_instr); end
  endtask

  task automatic test_reset_mid_run();
    flush = 1'b1; target = 32'h20;
    step();
    flush = 1'b0;
    step();
    vectors++; if (if_pc !== 32'h20) begin miscompares++; $display("FAIL mid_pre_pc got %h exp 20", if_pc); end
    rst = 1'b1; stall = 1'b1; flush = 1'b1; target = 32'h203;
    step();
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL mid_rst_pc got %h exp 0", if_pc); end
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b exp 0", if_valid); end
    vectors++; if (mem_addr !== 14'd0) begin miscompares++; $display("FAIL mid_rst_addr got %h exp 0", mem_addr); end
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL mid_rst_misalign got %b exp 0", misalign); end
    vectors++; if (if_instr !== 32'h13) begin miscompares++; $display("FAIL mid_rst_instr got %h exp 13", if_instr); end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    step();
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL rel_pc got %h exp 0", if_pc); end
    vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL rel_valid got %b exp 1", if_valid); end
    vectors++; if (if_instr !== 32'h1000_0000) begin miscompares++; $display("FAIL rel_instr got %h exp 10000000", if_instr); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; target = 32'h0000_FFFC;
    step();
    flush = 1'b0;
    vectors++; if (mem_addr !== 14'h3FFF) begin miscompares++; $display("FAIL wrap_addr got %h exp 3fff", mem_addr); end
    step();
    vectors++; if (if_instr !== 32'h1000_3FFF) begin miscompares++; $display("FAIL wrap_top_instr got %h exp 10003fff", if_instr); end
    step();
    vectors++; if (if_pc !== 32'h0001_0000) begin miscompares++; $display("FAIL alias_pc got %h exp 10000", if_pc); end
    vectors++; if (if_instr !== 32'h1000_0000) begin miscompares++; $display("FAIL alias_instr got %h exp 10000000", if_instr); end
    vectors++; if (if_pc4 !== 32'h0001_0004) begin miscompares++; $display("FAIL alias_pc4 got %h exp 10004", if_pc4); end
    flush = 1'b1; target = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    step();
    vectors++; if (if_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL top_pc got %h exp fffffffc", if_pc); end
    vectors++; if (if_pc4 !== 32'h0) begin miscompares++; $display("FAIL top_pc4 got %h exp 0", if_pc4); end
    step();
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %h exp 0", if_pc); end
    vectors++; if (if_instr !== 32'h1000_0000) begin miscompares++; $display("FAIL wrap_instr got %h exp 10000000", if_instr); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem_dout = 32'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_flush_over_stall();
    test_misalign();
    test_back_to_back();
    test_reset_mid_run();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
